// File: rtl/nco_iq_param.sv
// Quadrature phase-accumulator NCO with runtime frequency/offset loading, phase sync
// and a quarter-wave sine table built at elaboration.
module nco_iq_param #(
    parameter int ACC_W  = 16,
    parameter int LUT_AW = 10,
    parameter int OUT_W  = 18
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    cfg_load,
    input  logic [ACC_W-1:0]        phi_inc_i,
    input  logic [ACC_W-1:0]        phi_off_i,
    input  logic                    sync_i,
    output logic signed [OUT_W-1:0] fsin_o,
    output logic signed [OUT_W-1:0] fcos_o,
    output logic                    out_valid
);

    localparam int  N       = 2 ** LUT_AW;
    localparam int  PH_W    = LUT_AW + 2;
    localparam int  MAG_W   = OUT_W - 1;
    localparam real HALF_PI = 1.5707963267948966;
    localparam real AMP     = (2.0 ** (OUT_W - 1)) - 1.0;

    // Table entries use a Horner-form Taylor series (to x^15) so no math library is needed.
    logic [MAG_W-1:0] lut [N];

    for (genvar k = 0; k < N; k++) begin : g_lut
        localparam real         X  = HALF_PI * (k + 0.5) / N;
        localparam real         X2 = X * X;
        localparam real         S  = X * (1.0 - X2 / 6.0 * (1.0 - X2 / 20.0 * (1.0 - X2 / 42.0 *
                                     (1.0 - X2 / 72.0 * (1.0 - X2 / 110.0 * (1.0 - X2 / 156.0 *
                                     (1.0 - X2 / 210.0)))))));
        localparam int unsigned V  = $rtoi(AMP * S + 0.5);
        assign lut[k] = V[MAG_W-1:0];
    end

    logic [ACC_W-1:0]  inc_reg, off_reg, acc;
    logic [1:0]        fill;
    logic [ACC_W-1:0]  ph;
    logic [PH_W-1:0]   ph_top;
    logic [1:0]        q;
    logic [LUT_AW-1:0] idx;

    logic [1:0]        s2_q;
    logic [LUT_AW-1:0] s2_sin_addr, s2_cos_addr;
    logic [1:0]        s3_q;
    logic [MAG_W-1:0]  s3_sin_mag, s3_cos_mag;

    logic signed [OUT_W-1:0] sin_ext, cos_ext, sin_val, cos_val;

    always_comb begin
        ph     = acc + off_reg;
        ph_top = PH_W'(ph >> (ACC_W - PH_W));
        q      = ph_top[PH_W-1 -: 2];
        idx    = ph_top[LUT_AW-1:0];
    end

    // Cosine sits one quadrant ahead: its address mirrors on even q and negates on q=1,2.
    always_comb begin
        sin_ext = {1'b0, s3_sin_mag};
        cos_ext = {1'b0, s3_cos_mag};
        sin_val = s3_q[1] ? -sin_ext : sin_ext;
        cos_val = (s3_q[1] ^ s3_q[0]) ? -cos_ext : cos_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inc_reg     <= '0;
            off_reg     <= '0;
            acc         <= '0;
            s2_q        <= '0;
            s2_sin_addr <= '0;
            s2_cos_addr <= '0;
            s3_q        <= '0;
            s3_sin_mag  <= '0;
            s3_cos_mag  <= '0;
            fsin_o      <= '0;
            fcos_o      <= '0;
            fill        <= '0;
            out_valid   <= 1'b0;
        end else if (clken) begin
            if (cfg_load) begin
                inc_reg <= phi_inc_i;
                off_reg <= phi_off_i;
            end
            acc <= sync_i ? '0 : acc + inc_reg;

            s2_q        <= q;
            s2_sin_addr <= q[0] ? ~idx : idx;
            s2_cos_addr <= q[0] ? idx : ~idx;

            s3_q       <= s2_q;
            s3_sin_mag <= lut[s2_sin_addr];
            s3_cos_mag <= lut[s2_cos_addr];

            fsin_o <= sin_val;
            fcos_o <= cos_val;

            if (fill != 2'd3) fill <= fill + 2'd1;
            out_valid <= out_valid | (fill == 2'd2);
        end
    end

endmodule

// File: tb/tb_nco_iq_param.sv
// Self-checking bench for nco_iq_param: directed scenarios plus randomized traffic
// against an ideal-sinusoid latency model.
module tb_nco_iq_param;

    localparam int ACC_W  = 16;
    localparam int LUT_AW = 10;
    localparam int OUT_W  = 18;
    localparam int N      = 1 << LUT_AW;
    localparam int unsigned MASK = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic reset, clken, cfg_load, sync_i;
    logic [ACC_W-1:0] phi_inc_i, phi_off_i;
    logic signed [OUT_W-1:0] fsin_o, fcos_o;
    logic out_valid;

    nco_iq_param #(.ACC_W(ACC_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .clken(clken), .cfg_load(cfg_load),
        .phi_inc_i(phi_inc_i), .phi_off_i(phi_off_i), .sync_i(sync_i),
        .fsin_o(fsin_o), .fcos_o(fcos_o), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    int unsigned m_inc, m_off, m_acc, m_en;
    int unsigned phq[$];
    logic signed [OUT_W-1:0] e_sin, e_cos;
    logic e_valid;
    logic e_known;

    logic signed [OUT_W-1:0] ps [4] = '{18'sd101, 18'sd131071, -18'sd101, -18'sd131071};
    logic signed [OUT_W-1:0] pc [4] = '{18'sd131071, -18'sd101, -18'sd131071, 18'sd101};

    // Ideal sample for a phase word: angle is the centre of its table bin.
    function automatic logic signed [OUT_W-1:0] ideal(input int unsigned ph, input bit cosine);
        real ang, v, a;
        int r;
        ang = 2.0 * 3.141592653589793 * (real'(ph >> (ACC_W - LUT_AW - 2)) + 0.5) / real'(4 * N);
        v   = cosine ? $cos(ang) : $sin(ang);
        a   = ((2.0 ** (OUT_W - 1)) - 1.0) * v;
        r   = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
        return OUT_W'(r);
    endfunction

    task automatic cycle(input logic r, input logic e, input logic ld, input logic sy,
                         input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] off);
        int unsigned p;
        reset = r; clken = e; cfg_load = ld; sync_i = sy; phi_inc_i = inc; phi_off_i = off;
        @(posedge clk);
        if (r) begin
            m_inc = 0; m_off = 0; m_acc = 0; m_en = 0;
            phq.delete();
            e_sin = '0; e_cos = '0; e_valid = 1'b0; e_known = 1'b1;
        end else if (e) begin
            phq.push_back((m_acc + m_off) & MASK);
            m_acc = sy ? 0 : ((m_acc + m_inc) & MASK);
            if (ld) begin
                m_inc = inc;
                m_off = off;
            end
            if (m_en < 3) m_en++;
            if (phq.size() == 3) begin
                p = phq.pop_front();
                e_sin = ideal(p, 1'b0);
                e_cos = ideal(p, 1'b1);
            end
            e_valid = (m_en >= 3);
            e_known = e_valid;
        end
        #1;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
            compared++;
            if ({fsin_o, fcos_o, out_valid} !== {18'sd0, 18'sd0, 1'b0}) begin
                mismatched++;
                $display("FAIL reset_state: got sin=%0d cos=%0d v=%b want 0 0 0", fsin_o, fcos_o, out_valid);
            end
        end
    endtask

    task automatic test_const;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 1'b1, k == 1, 1'b0, '0, '0);
            compared++;
            if (out_valid !== e_valid || (e_known && {fsin_o, fcos_o} !== {e_sin, e_cos})) begin
                mismatched++;
                $display("FAIL const_model k=%0d: got %0d %0d %b want %0d %0d %b", k, fsin_o, fcos_o, out_valid, e_sin, e_cos, e_valid);
            end
            if (k >= 3) begin
                compared++;
                if ({fsin_o, fcos_o, out_valid} !== {18'sd101, 18'sd131071, 1'b1}) begin
                    mismatched++;
                    $display("FAIL const_value k=%0d: got %0d %0d %b want 101 131071 1", k, fsin_o, fcos_o, out_valid);
                end
            end
        end
    endtask

    task automatic test_quarter;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int e = 1; e <= 12; e++) begin
            cycle(1'b0, 1'b1, e == 1, 1'b0, 16'h4000, 16'h0000);
            compared++;
            if (out_valid !== e_valid || (e_known && {fsin_o, fcos_o} !== {e_sin, e_cos})) begin
                mismatched++;
                $display("FAIL quarter_model e=%0d: got %0d %0d %b want %0d %0d %b", e, fsin_o, fcos_o, out_valid, e_sin, e_cos, e_valid);
            end
            if (e >= 4) begin
                compared++;
                if ({fsin_o, fcos_o, out_valid} !== {ps[(e-4)%4], pc[(e-4)%4], 1'b1}) begin
                    mismatched++;
                    $display("FAIL quarter_pattern e=%0d: got %0d %0d want %0d %0d", e, fsin_o, fcos_o, ps[(e-4)%4], pc[(e-4)%4]);
                end
            end
        end
    endtask

    task automatic test_sync;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h4000, 16'h8000);
        for (int d = 1; d <= 6; d++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678);
            compared++;
            if (out_valid !== e_valid || (e_known && {fsin_o, fcos_o} !== {e_sin, e_cos})) begin
                mismatched++;
                $display("FAIL sync_model d=%0d: got %0d %0d %b want %0d %0d %b", d, fsin_o, fcos_o, out_valid, e_sin, e_cos, e_valid);
            end
            if (d >= 3) begin
                compared++;
                if ({fsin_o, fcos_o, out_valid} !== {ps[(d-1)%4], pc[(d-1)%4], 1'b1}) begin
                    mismatched++;
                    $display("FAIL sync_pattern d=%0d: got %0d %0d want %0d %0d", d, fsin_o, fcos_o, ps[(d-1)%4], pc[(d-1)%4]);
                end
            end
        end
    endtask

    task automatic test_clken;
        int ne = 0;
        logic en;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 400 && ne < 16; c++) begin
            en = 1'($urandom_range(0, 1));
            if (en) cycle(1'b0, 1'b1, ne == 0, 1'b0, 16'h4000, 16'h0000);
            else    cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), ACC_W'($urandom), ACC_W'($urandom));
            if (en) ne++;
            compared++;
            if (out_valid !== e_valid || (e_known && {fsin_o, fcos_o} !== {e_sin, e_cos})) begin
                mismatched++;
                $display("FAIL clken_model c=%0d: got %0d %0d %b want %0d %0d %b", c, fsin_o, fcos_o, out_valid, e_sin, e_cos, e_valid);
            end
            if (ne >= 4) begin
                compared++;
                if ({fsin_o, fcos_o, out_valid} !== {ps[(ne-4)%4], pc[(ne-4)%4], 1'b1}) begin
                    mismatched++;
                    $display("FAIL clken_pattern ne=%0d: got %0d %0d want %0d %0d", ne, fsin_o, fcos_o, ps[(ne-4)%4], pc[(ne-4)%4]);
                end
            end
        end
        compared++;
        if (ne < 16) begin
            mismatched++;
            $display("FAIL clken_budget: got %0d enabled cycles want 16", ne);
        end
    endtask

    task automatic test_reset_midstream;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        compared++;
        if ({fsin_o, fcos_o, out_valid} !== {18'sd0, 18'sd0, 1'b0}) begin
            mismatched++;
            $display("FAIL midreset_state: got %0d %0d %b want 0 0 0", fsin_o, fcos_o, out_valid);
        end
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
            compared++;
            if (out_valid !== (k >= 3) || (k >= 3 && {fsin_o, fcos_o} !== {18'sd101, 18'sd131071})) begin
                mismatched++;
                $display("FAIL midreset_refill k=%0d: got %0d %0d %b want valid=%0d 101 131071", k, fsin_o, fcos_o, out_valid, k >= 3);
            end
        end
    endtask

    task automatic test_neg_freq;
        int maxabs = 0;
        int s;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 70000; c++) begin
            cycle(1'b0, 1'b1, c == 0, 1'b0, 16'hFFFF, 16'h0000);
            compared++;
            if (out_valid !== e_valid || (e_known && {fsin_o, fcos_o} !== {e_sin, e_cos})) begin
                mismatched++;
                $display("FAIL negfreq_model c=%0d: got %0d %0d %b want %0d %0d %b", c, fsin_o, fcos_o, out_valid, e_sin, e_cos, e_valid);
            end
            if (out_valid === 1'b1) begin
                s = int'(fsin_o);
                if (s < 0) s = -s;
                if (s > maxabs) maxabs = s;
            end
        end
        compared++;
        if (maxabs != 131071) begin
            mismatched++;
            $display("FAIL negfreq_peak: got %0d want 131071", maxabs);
        end
    endtask

    task automatic test_random;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 3000; c++) begin
            cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0),
                  ACC_W'($urandom), ACC_W'($urandom));
            compared++;
            if (out_valid !== e_valid || (e_known && {fsin_o, fcos_o} !== {e_sin, e_cos})) begin
                mismatched++;
                $display("FAIL random_model c=%0d: got %0d %0d %b want %0d %0d %b", c, fsin_o, fcos_o, out_valid, e_sin, e_cos, e_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_quarter();
        test_sync();
        test_clken();
        test_reset_midstream();
        test_neg_freq();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
